// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter sharing one downstream valid/ready channel among N requesters.
// Grants last at most BURST beats; data is muxed combinationally from the registered grant.
module vr_rr_arbiter #(
    parameter int N     = 4,
    parameter int DATA  = 32,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N-1:0]          s_valid,
    output logic [N-1:0]          s_ready,
    input  logic [N*DATA-1:0]     s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA-1:0]       m_data,
    output logic [$clog2(N)-1:0]  m_grant_id,
    output logic                  busy
);

    localparam int GW = $clog2(N);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] grant, grant_nxt;
    logic [GW-1:0] last, last_nxt;
    logic [GW-1:0] sel;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          found;
    logic          owner_valid;
    logic          hs;

    assign owner_valid = s_valid[grant];
    assign hs          = owner_valid & m_ready;

    // Search upward from last+1 with wrap-around so the previous owner goes to the back.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && s_valid[(int'(last) + i) % N]) begin
                sel   = GW'((int'(last) + i) % N);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            last  <= GW'(N - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    grant_nxt = sel;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                // Release only on the final burst beat or when the owner offers nothing.
                if (hs) begin
                    if (cnt == CW'(BURST - 1)) begin
                        state_nxt = IDLE;
                        last_nxt  = grant;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (!owner_valid) begin
                    state_nxt = IDLE;
                    last_nxt  = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_valid    = 1'b0;
        m_data     = '0;
        s_ready    = '0;
        busy       = 1'b0;
        m_grant_id = grant;
        if (state == GRANT) begin
            busy           = 1'b1;
            m_valid        = owner_valid;
            m_data         = s_data[int'(grant)*DATA +: DATA];
            s_ready[grant] = m_ready;
        end
    end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter: per-cycle expected traces written by hand,
// with a small source model that holds data until each beat handshakes.
module tb_vr_rr_arbiter;

    localparam int N     = 4;
    localparam int DATA  = 32;
    localparam int BURST = 4;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    logic [N*DATA-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA-1:0]   m_data;
    logic [1:0]        m_grant_id;
    logic              busy;

    int n_cmp;
    int n_err;
    int rem [N];
    int idx [N];

    vr_rr_arbiter #(.N(N), .DATA(DATA), .BURST(BURST)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_grant_id (m_grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int r, input int k);
        return {16'hC0DE, 8'(r), 8'(k)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_valid[i]           = (rem[i] != 0);
            s_data[i*DATA +: DATA] = mk(i, idx[i]);
        end
    endtask

    task automatic applyStimulus(input int req, input int beats);
        rem[req] += beats;
        drive();
    endtask

    // Trace chars: '.' idle, '0'..'3' owner offering a beat, 'a'..'d' owner with valid low.
    task automatic run_trace(input string tag, input string exp_s, input string rdy_s);
        for (int c = 0; c < exp_s.len(); c++) begin
            byte            e;
            int             g;
            logic [N-1:0]   hs;
            logic [63:0]    ev;
            logic [63:0]    ov;
            m_ready = (rdy_s.len() == 0) ? 1'b1 : (rdy_s[c] == "1");
            #1;
            e  = exp_s[c];
            ev = '0;
            g  = -1;
            if (e >= "0" && e <= "3") begin
                g  = int'(e) - int'("0");
                ev = {24'd0, 1'b1, 2'(g), 1'b1, 4'(m_ready) << g, mk(g, idx[g])};
            end else if (e >= "a" && e <= "d") begin
                g  = int'(e) - int'("a");
                ev = {24'd0, 1'b1, 2'(g), 1'b0, 4'(m_ready) << g, mk(g, idx[g])};
            end
            ov = {24'd0, busy, busy ? m_grant_id : 2'd0, m_valid, s_ready, m_data};
            checkOutput($sformatf("%s c%0d", tag, c), ov, ev);
            hs = s_valid & s_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    rem[i]--;
                    idx[i]++;
                end
            end
            drive();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput(tag, {24'd0, busy, m_grant_id, m_valid, s_ready, m_data}, 64'd0);
    endtask

    initial begin
        int total;
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        m_ready = 1'b0;
        s_valid = '0;
        s_data  = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            idx[i] = 0;
        end
        drive();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        applyStimulus(1, 6);
        run_trace("single", ".1111.11b.", "");

        // Restore last=N-1 so requester 0 leads the rotation.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) applyStimulus(i, 5);
        run_trace("rr", ".0000.1111.2222.3333.0a.1b.2c.3d.", "");

        applyStimulus(2, 4);
        run_trace("bp", ".222222222.", "11100000111");

        applyStimulus(3, 2);
        applyStimulus(0, 3);
        run_trace("early", ".33d.000a.", "");

        applyStimulus(1, 4);
        run_trace("pre_rst", ".11", "");
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #1;
        reset_n = 1'b1;
        applyStimulus(2, 2);
        run_trace("post_rst", ".11b.22c.", "");

        applyStimulus(3, 1);
        run_trace("set_last", ".3d.", "");
        applyStimulus(0, 1);
        applyStimulus(2, 1);
        run_trace("wrap", ".0a.2c.", "");

        total = 0;
        for (int i = 0; i < N; i++) total += rem[i];
        checkOutput("drained", 64'(total), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
